// File: rtl/ibex_lsu_resp_unit.sv
// Load/store response unit: accepts one LSU request at a time, runs the
// req/gnt/rvalid data-bus handshake (splitting misaligned accesses into two
// aligned words), and returns aligned, extended load data with a one-cycle
// response pulse.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no transaction; a request is accepted here
// GNT1  | first (or only) bus request asserted, waiting for grant
// RVAL1 | first bus access granted, waiting for its response
// GNT2  | second word of a misaligned access requested, waiting for grant
// RVAL2 | second bus access granted, waiting for its response
module ibex_lsu_resp_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [1:0]  lsu_type_i,
  input  logic        lsu_sign_ext_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_busy_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i,
  output logic [31:0] rf_wdata_lsu_o,
  output logic        rf_we_lsu_o,
  output logic        lsu_resp_valid_o,
  output logic        lsu_resp_err_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GNT1  = 3'd1,
    RVAL1 = 3'd2,
    GNT2  = 3'd3,
    RVAL2 = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [1:0]  type_q;
  logic        we_q, sign_q, err_q;

  logic        accept;
  logic        is_word, is_half, mis;
  logic [1:0]  off;
  logic [4:0]  shamt;
  logic [3:0]  base_be;
  logic [7:0]  be_ext;
  logic [63:0] ld_data;
  logic [31:0] ld_word, ld_ext;
  logic        resp_valid, resp_err;

  assign accept  = (state_q == IDLE) & lsu_req_i;
  assign off     = addr_q[1:0];
  assign shamt   = {off, 3'b000};
  // Type 11 has no meaning of its own and behaves as a word access.
  assign is_word = (type_q == 2'b00) | (type_q == 2'b11);
  assign is_half = (type_q == 2'b01);
  assign mis     = (is_word & (off != 2'b00)) | (is_half & (off == 2'b11));
  assign base_be = is_word ? 4'b1111 : (is_half ? 4'b0011 : 4'b0001);
  // Low nibble covers the first word, high nibble spills into the next word.
  assign be_ext  = {4'b0000, base_be} << off;

  assign lsu_busy_o   = (state_q != IDLE);
  assign data_we_o    = we_q;
  // Store data rotated so each byte lands in its lane in both words.
  assign data_wdata_o = (wdata_q << shamt) | (wdata_q >> (6'd32 - {1'b0, shamt}));

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Captured request and first-word response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q  <= 32'b0;
      wdata_q <= 32'b0;
      rdata_q <= 32'b0;
      type_q  <= 2'b00;
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= lsu_addr_i;
        wdata_q <= lsu_wdata_i;
        type_q  <= lsu_type_i;
        we_q    <= lsu_we_i;
        sign_q  <= lsu_sign_ext_i;
      end
      if ((state_q == RVAL1) && data_rvalid_i) begin
        rdata_q <= data_rdata_i;
        err_q   <= data_err_i;
      end
    end
  end

  // Next-state, bus request and response pulse.
  always_comb begin
    state_d     = state_q;
    data_req_o  = 1'b0;
    data_be_o   = 4'b0000;
    data_addr_o = {addr_q[31:2], 2'b00};
    resp_valid  = 1'b0;
    resp_err    = 1'b0;
    case (state_q)
      IDLE: begin
        if (lsu_req_i) state_d = GNT1;
      end
      GNT1: begin
        data_req_o = 1'b1;
        data_be_o  = be_ext[3:0];
        if (data_gnt_i) state_d = RVAL1;
      end
      RVAL1: begin
        if (data_rvalid_i) begin
          if (mis) begin
            state_d = GNT2;
          end else begin
            state_d    = IDLE;
            resp_valid = 1'b1;
            resp_err   = data_err_i;
          end
        end
      end
      GNT2: begin
        data_req_o  = 1'b1;
        data_be_o   = be_ext[7:4];
        data_addr_o = {addr_q[31:2] + 30'd1, 2'b00};
        if (data_gnt_i) state_d = RVAL2;
      end
      RVAL2: begin
        // A first-part error is only accumulated, never short-circuits.
        if (data_rvalid_i) begin
          state_d    = IDLE;
          resp_valid = 1'b1;
          resp_err   = err_q | data_err_i;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ld_data = mis ? {data_rdata_i, rdata_q} : {32'b0, data_rdata_i};
  assign ld_word = 32'(ld_data >> shamt);

  // Size selection and sign/zero extension of the aligned load data.
  always_comb begin
    ld_ext = ld_word;
    if (is_half) begin
      ld_ext = {{16{sign_q & ld_word[15]}}, ld_word[15:0]};
    end else if (!is_word) begin
      ld_ext = {{24{sign_q & ld_word[7]}}, ld_word[7:0]};
    end
  end

  assign rf_wdata_lsu_o   = we_q ? 32'b0 : ld_ext;
  assign lsu_resp_valid_o = resp_valid;
  assign lsu_resp_err_o   = resp_err;
  assign rf_we_lsu_o      = resp_valid & ~we_q & ~resp_err;

endmodule

// File: tb/tb_ibex_lsu_resp_unit.sv
// Bench for ibex_lsu_resp_unit: directed scenarios plus randomized
// transactions checked against a byte-level memory model.
module tb_ibex_lsu_resp_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        lsu_req_i, lsu_we_i, lsu_sign_ext_i;
  logic [1:0]  lsu_type_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i;
  logic        lsu_busy_o;
  logic        data_req_o, data_gnt_i, data_we_o;
  logic [31:0] data_addr_o, data_wdata_o;
  logic [3:0]  data_be_o;
  logic        data_rvalid_i, data_err_i;
  logic [31:0] data_rdata_i;
  logic [31:0] rf_wdata_lsu_o;
  logic        rf_we_lsu_o, lsu_resp_valid_o, lsu_resp_err_o;

  int checks = 0;
  int failures = 0;

  ibex_lsu_resp_unit dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_type_i(lsu_type_i),
    .lsu_sign_ext_i(lsu_sign_ext_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_busy_o(lsu_busy_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o),
    .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
    .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i), .data_err_i(data_err_i),
    .rf_wdata_lsu_o(rf_wdata_lsu_o), .rf_we_lsu_o(rf_we_lsu_o),
    .lsu_resp_valid_o(lsu_resp_valid_o), .lsu_resp_err_o(lsu_resp_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Observations of one transaction
  int          obs_nreq, obs_nresp;
  logic [31:0] obs_addr [4];
  logic [31:0] obs_wdata [4];
  logic [3:0]  obs_be [4];
  logic        obs_we [4];
  logic        obs_unstable, obs_timeout, obs_busy_acc, obs_busy_after, obs_extra;
  logic [31:0] obs_rf_wdata;
  logic        obs_rf_we, obs_err;

  // Model expectations
  int          exp_nreq;
  logic [31:0] exp_addr [2];
  logic [31:0] exp_wdata [2];
  logic [3:0]  exp_be [2];
  logic [31:0] exp_result;
  logic        exp_err, exp_rfwe;

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    m = 32'b0;
    for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  // Byte-level model: the access touches bytes addr..addr+n-1 of a
  // little-endian memory whose words at the two addresses read rd0/rd1.
  task automatic model(input logic [31:0] addr, input logic we, input logic [1:0] typ,
                       input logic sign, input logic [31:0] wdata,
                       input logic [31:0] rd0, input logic [31:0] rd1,
                       input logic e0, input logic e1);
    int n, off, pos;
    logic [31:0] rd [2];
    n   = (typ == 2'b01) ? 2 : ((typ == 2'b10) ? 1 : 4);
    off = int'(addr[1:0]);
    exp_nreq    = (off + n > 4) ? 2 : 1;
    exp_addr[0] = {addr[31:2], 2'b00};
    exp_addr[1] = exp_addr[0] + 32'd4;
    exp_be[0] = 4'b0; exp_be[1] = 4'b0;
    exp_wdata[0] = 32'b0; exp_wdata[1] = 32'b0;
    exp_result = 32'b0;
    rd[0] = rd0; rd[1] = rd1;
    for (int i = 0; i < n; i++) begin
      pos = off + i;
      exp_be[pos/4][pos%4] = 1'b1;
      exp_wdata[pos/4][8*(pos%4) +: 8] = wdata[8*i +: 8];
      exp_result[8*i +: 8] = rd[pos/4][8*(pos%4) +: 8];
    end
    if (sign && exp_result[8*n-1])
      for (int i = n; i < 4; i++) exp_result[8*i +: 8] = 8'hFF;
    if (we) exp_result = 32'b0;
    exp_err  = e0 | ((exp_nreq == 2) && e1);
    exp_rfwe = !we && !exp_err;
  endtask

  // Issues one request (caller positioned just after a negedge) and acts as
  // the bus slave until the response, recording what the DUT did.
  task automatic run_txn(input logic [31:0] addr, input logic we, input logic [1:0] typ,
                         input logic sign, input logic [31:0] wdata,
                         input logic [31:0] rd0, input logic [31:0] rd1,
                         input logic e0, input logic e1, input int gdly, input int rdly);
    int  cyc, k, stall, wait_r, idx;
    bit  pending, done;
    obs_nreq = 0; obs_nresp = 0; obs_unstable = 0; obs_timeout = 0;
    obs_rf_wdata = 32'b0; obs_rf_we = 0; obs_err = 0;
    cyc = 0; k = 0; stall = 0; wait_r = 0; pending = 0; done = 0;
    lsu_req_i = 1; lsu_addr_i = addr; lsu_we_i = we; lsu_type_i = typ;
    lsu_sign_ext_i = sign; lsu_wdata_i = wdata;
    #1 obs_busy_acc = lsu_busy_o;
    @(negedge clk_i);
    lsu_req_i = 0; lsu_addr_i = $urandom; lsu_we_i = 1'($urandom);
    lsu_type_i = 2'($urandom); lsu_sign_ext_i = 1'($urandom); lsu_wdata_i = $urandom;
    while (!done && cyc < 60) begin
      data_gnt_i = 0; data_rvalid_i = 0; data_err_i = 0; data_rdata_i = $urandom;
      if (pending) begin
        if (wait_r >= rdly) begin
          data_rvalid_i = 1;
          data_rdata_i  = (k == 0) ? rd0 : rd1;
          data_err_i    = (k == 0) ? e0 : e1;
          pending = 0;
          k++;
        end else begin
          wait_r++;
        end
      end
      #1;
      if (data_req_o) begin
        if (stall == 0) begin
          if (obs_nreq < 4) begin
            obs_addr[obs_nreq] = data_addr_o; obs_be[obs_nreq] = data_be_o;
            obs_we[obs_nreq] = data_we_o; obs_wdata[obs_nreq] = data_wdata_o;
          end
          obs_nreq++;
        end else begin
          idx = (obs_nreq > 4) ? 3 : obs_nreq - 1;
          if (data_addr_o !== obs_addr[idx] || data_be_o !== obs_be[idx] ||
              data_we_o !== obs_we[idx] || data_wdata_o !== obs_wdata[idx])
            obs_unstable = 1;
        end
        if (stall >= gdly) begin
          data_gnt_i = 1; pending = 1; wait_r = 0; stall = 0;
        end else begin
          stall++;
        end
      end
      if (lsu_resp_valid_o) begin
        obs_nresp++;
        obs_rf_wdata = rf_wdata_lsu_o; obs_rf_we = rf_we_lsu_o; obs_err = lsu_resp_err_o;
        done = 1;
      end
      @(negedge clk_i);
      cyc++;
    end
    obs_timeout = !done;
    data_gnt_i = 0; data_rvalid_i = 0; data_err_i = 0;
    #1;
    obs_busy_after = lsu_busy_o;
    obs_extra      = lsu_resp_valid_o;
  endtask

  task automatic test_reset;
    rst_i = 1;
    repeat (3) @(negedge clk_i);
    #1;
    checks++; if (lsu_busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", lsu_busy_o); end
    checks++; if (data_req_o !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", data_req_o); end
    checks++; if (lsu_resp_valid_o !== 1'b0) begin failures++; $display("FAIL rst_resp got=%b exp=0", lsu_resp_valid_o); end
    checks++; if (lsu_resp_err_o !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", lsu_resp_err_o); end
    checks++; if (rf_we_lsu_o !== 1'b0) begin failures++; $display("FAIL rst_rfwe got=%b exp=0", rf_we_lsu_o); end
    rst_i = 0;
  endtask

  task automatic test_aligned_word;
    run_txn(32'h100, 0, 2'b00, 0, 32'h0, 32'hDEADBEEF, 32'h0, 0, 0, 0, 0);
    checks++; if (obs_timeout) begin failures++; $display("FAIL aw_timeout got=1 exp=0"); end
    checks++; if (obs_nreq !== 1) begin failures++; $display("FAIL aw_nreq got=%0d exp=1", obs_nreq); end
    checks++; if (obs_addr[0] !== 32'h100) begin failures++; $display("FAIL aw_addr got=%h exp=00000100", obs_addr[0]); end
    checks++; if (obs_be[0] !== 4'b1111) begin failures++; $display("FAIL aw_be got=%b exp=1111", obs_be[0]); end
    checks++; if (obs_nresp !== 1 || obs_extra !== 1'b0) begin failures++; $display("FAIL aw_resp got=%0d/%b exp=1/0", obs_nresp, obs_extra); end
    checks++; if (obs_rf_we !== 1'b1) begin failures++; $display("FAIL aw_rfwe got=%b exp=1", obs_rf_we); end
    checks++; if (obs_rf_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL aw_data got=%h exp=deadbeef", obs_rf_wdata); end
    checks++; if (obs_busy_after !== 1'b0) begin failures++; $display("FAIL aw_busy_after got=%b exp=0", obs_busy_after); end
  endtask

  task automatic test_signed_byte;
    run_txn(32'h103, 0, 2'b10, 1, 32'h0, 32'h80FFFFFF, 32'h0, 0, 0, 0, 1);
    checks++; if (obs_be[0] !== 4'b1000) begin failures++; $display("FAIL sb_be got=%b exp=1000", obs_be[0]); end
    checks++; if (obs_rf_wdata !== 32'hFFFFFF80) begin failures++; $display("FAIL sb_sext got=%h exp=ffffff80", obs_rf_wdata); end
    run_txn(32'h103, 0, 2'b10, 0, 32'h0, 32'h80FFFFFF, 32'h0, 0, 0, 1, 0);
    checks++; if (obs_rf_wdata !== 32'h00000080) begin failures++; $display("FAIL sb_zext got=%h exp=00000080", obs_rf_wdata); end
  endtask

  task automatic test_mis_word;
    run_txn(32'h201, 0, 2'b00, 0, 32'h0, 32'h44332211, 32'h88776655, 0, 0, 0, 0);
    checks++; if (obs_nreq !== 2) begin failures++; $display("FAIL mw_nreq got=%0d exp=2", obs_nreq); end
    checks++; if (obs_addr[0] !== 32'h200 || obs_be[0] !== 4'b1110) begin failures++; $display("FAIL mw_req1 got=%h/%b exp=00000200/1110", obs_addr[0], obs_be[0]); end
    checks++; if (obs_addr[1] !== 32'h204 || obs_be[1] !== 4'b0001) begin failures++; $display("FAIL mw_req2 got=%h/%b exp=00000204/0001", obs_addr[1], obs_be[1]); end
    checks++; if (obs_rf_wdata !== 32'h55443322) begin failures++; $display("FAIL mw_data got=%h exp=55443322", obs_rf_wdata); end
    checks++; if (obs_nresp !== 1 || obs_extra !== 1'b0) begin failures++; $display("FAIL mw_pulses got=%0d/%b exp=1/0", obs_nresp, obs_extra); end
  endtask

  task automatic test_mis_half_store;
    run_txn(32'h3FF, 1, 2'b01, 0, 32'h0000ABCD, 32'h0, 32'h0, 0, 0, 0, 0);
    checks++; if (obs_addr[0] !== 32'h3FC || obs_be[0] !== 4'b1000 || obs_we[0] !== 1'b1) begin failures++; $display("FAIL hs_req1 got=%h/%b/%b exp=000003fc/1000/1", obs_addr[0], obs_be[0], obs_we[0]); end
    checks++; if (obs_wdata[0][31:24] !== 8'hCD) begin failures++; $display("FAIL hs_wdata1 got=%h exp=cd", obs_wdata[0][31:24]); end
    checks++; if (obs_addr[1] !== 32'h400 || obs_be[1] !== 4'b0001) begin failures++; $display("FAIL hs_req2 got=%h/%b exp=00000400/0001", obs_addr[1], obs_be[1]); end
    checks++; if (obs_wdata[1][7:0] !== 8'hAB) begin failures++; $display("FAIL hs_wdata2 got=%h exp=ab", obs_wdata[1][7:0]); end
    checks++; if (obs_nresp !== 1 || obs_rf_we !== 1'b0) begin failures++; $display("FAIL hs_resp got=%0d/%b exp=1/0", obs_nresp, obs_rf_we); end
    checks++; if (obs_rf_wdata !== 32'h0) begin failures++; $display("FAIL hs_rfdata got=%h exp=00000000", obs_rf_wdata); end
  endtask

  task automatic test_err_stall;
    run_txn(32'h502, 0, 2'b00, 0, 32'h0, 32'h11111111, 32'h22222222, 1, 0, 3, 1);
    checks++; if (obs_nreq !== 2) begin failures++; $display("FAIL es_nreq got=%0d exp=2", obs_nreq); end
    checks++; if (obs_unstable !== 1'b0) begin failures++; $display("FAIL es_stable got=%b exp=0", obs_unstable); end
    checks++; if (obs_err !== 1'b1) begin failures++; $display("FAIL es_err got=%b exp=1", obs_err); end
    checks++; if (obs_rf_we !== 1'b0) begin failures++; $display("FAIL es_rfwe got=%b exp=0", obs_rf_we); end
    checks++; if (obs_nresp !== 1) begin failures++; $display("FAIL es_nresp got=%0d exp=1", obs_nresp); end
  endtask

  task automatic test_reset_mid;
    lsu_req_i = 1; lsu_addr_i = 32'h600; lsu_we_i = 0; lsu_type_i = 2'b00;
    lsu_sign_ext_i = 0; lsu_wdata_i = 32'h0;
    @(negedge clk_i);
    lsu_req_i = 0; data_gnt_i = 1;
    @(negedge clk_i);
    data_gnt_i = 0; rst_i = 1;
    #1;
    checks++; if (lsu_busy_o !== 1'b1) begin failures++; $display("FAIL rm_inflight got=%b exp=1", lsu_busy_o); end
    @(negedge clk_i);
    rst_i = 0; data_rvalid_i = 1; data_rdata_i = 32'h12345678; data_err_i = 0;
    #1;
    checks++; if (lsu_resp_valid_o !== 1'b0) begin failures++; $display("FAIL rm_stray_resp got=%b exp=0", lsu_resp_valid_o); end
    checks++; if (lsu_busy_o !== 1'b0 || data_req_o !== 1'b0) begin failures++; $display("FAIL rm_idle got=%b/%b exp=0/0", lsu_busy_o, data_req_o); end
    @(negedge clk_i);
    data_rvalid_i = 0;
    #1;
    checks++; if (lsu_resp_valid_o !== 1'b0 || lsu_busy_o !== 1'b0) begin failures++; $display("FAIL rm_after got=%b/%b exp=0/0", lsu_resp_valid_o, lsu_busy_o); end
    run_txn(32'h704, 0, 2'b01, 1, 32'h0, 32'h0000F00D, 32'h0, 0, 0, 0, 0);
    checks++; if (obs_nresp !== 1 || obs_rf_wdata !== 32'hFFFFF00D) begin failures++; $display("FAIL rm_new got=%0d/%h exp=1/fffff00d", obs_nresp, obs_rf_wdata); end
  endtask

  // Randomized back-to-back transactions, each accepted in the first idle cycle.
  task automatic test_random;
    logic [31:0] a, wd, r0, r1;
    logic        w, s, e0, e1;
    logic [1:0]  t;
    int          g, r;
    for (int n = 0; n < 80; n++) begin
      a = $urandom; wd = $urandom; r0 = $urandom; r1 = $urandom;
      if (n % 8 == 0) a[31:2] = 30'h3FFFFFFF;
      w = 1'($urandom); s = 1'($urandom); t = 2'($urandom);
      e0 = ($urandom_range(0, 7) == 0); e1 = ($urandom_range(0, 7) == 0);
      g = $urandom_range(0, 2); r = $urandom_range(0, 2);
      model(a, w, t, s, wd, r0, r1, e0, e1);
      run_txn(a, w, t, s, wd, r0, r1, e0, e1, g, r);
      checks++; if (obs_timeout || obs_nresp !== 1 || obs_extra !== 1'b0) begin failures++; $display("FAIL rnd_resp txn=%0d got=%0d/%b/%b exp=1/0/0", n, obs_nresp, obs_extra, obs_timeout); end
      checks++; if (obs_busy_acc !== 1'b0 || obs_busy_after !== 1'b0) begin failures++; $display("FAIL rnd_busy txn=%0d got=%b/%b exp=0/0", n, obs_busy_acc, obs_busy_after); end
      checks++; if (obs_nreq !== exp_nreq) begin failures++; $display("FAIL rnd_nreq txn=%0d got=%0d exp=%0d", n, obs_nreq, exp_nreq); end
      for (int q = 0; q < exp_nreq && q < obs_nreq; q++) begin
        checks++;
        if (obs_addr[q] !== exp_addr[q] || obs_be[q] !== exp_be[q] || obs_we[q] !== w) begin
          failures++;
          $display("FAIL rnd_bus txn=%0d part=%0d got=%h/%b/%b exp=%h/%b/%b", n, q, obs_addr[q], obs_be[q], obs_we[q], exp_addr[q], exp_be[q], w);
        end
        if (w) begin
          checks++;
          if ((obs_wdata[q] & lane_mask(exp_be[q])) !== exp_wdata[q]) begin
            failures++;
            $display("FAIL rnd_wdata txn=%0d part=%0d got=%h exp=%h", n, q, obs_wdata[q] & lane_mask(exp_be[q]), exp_wdata[q]);
          end
        end
      end
      checks++; if (obs_unstable !== 1'b0) begin failures++; $display("FAIL rnd_stable txn=%0d got=1 exp=0", n); end
      checks++; if (obs_err !== exp_err || obs_rf_we !== exp_rfwe) begin failures++; $display("FAIL rnd_err txn=%0d got=%b/%b exp=%b/%b", n, obs_err, obs_rf_we, exp_err, exp_rfwe); end
      checks++; if (obs_rf_wdata !== exp_result) begin failures++; $display("FAIL rnd_data txn=%0d got=%h exp=%h", n, obs_rf_wdata, exp_result); end
    end
  endtask

  initial begin
    rst_i = 1; lsu_req_i = 0; lsu_we_i = 0; lsu_type_i = 2'b00; lsu_sign_ext_i = 0;
    lsu_addr_i = 32'h0; lsu_wdata_i = 32'h0;
    data_gnt_i = 0; data_rvalid_i = 0; data_rdata_i = 32'h0; data_err_i = 0;
    test_reset;
    test_aligned_word;
    test_signed_byte;
    test_mis_word;
    test_mis_half_store;
    test_err_stall;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
